dmi_arbiter: RTL and testbench

- Shares the single Debug Module DMI slave port (dm_top) between two DMI masters: requester 0 is the JTAG DTM, requester 1 is a secondary host bridge such as a UART debug link.
- Exactly one DMI transaction is outstanding at a time. Requesters are granted round-robin.
- The request is registered, forwarded to the DM, and the DM response is routed back to the granted requester only.
- Sits between the DTM/bridge and dm_top inside ibex_soc.

---
 rtl/dmi_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dmi_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing the Debug Module DMI port between two DMI masters.
// Optional watchdog: define DMI_ARB_TIMEOUT_EN.
module dmi_arbiter #(
  parameter int unsigned ABITS          = 7,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             m0_req_valid_i,
  output logic             m0_req_ready_o,
  input  logic [ABITS-1:0] m0_req_addr_i,
  input  logic [1:0]       m0_req_op_i,
  input  logic [31:0]      m0_req_data_i,
  output logic             m0_resp_valid_o,
  input  logic             m0_resp_ready_i,
  output logic [31:0]      m0_resp_data_o,
  output logic [1:0]       m0_resp_resp_o,
  input  logic             m1_req_valid_i,
  output logic             m1_req_ready_o,
  input  logic [ABITS-1:0] m1_req_addr_i,
  input  logic [1:0]       m1_req_op_i,
  input  logic [31:0]      m1_req_data_i,
  output logic             m1_resp_valid_o,
  input  logic             m1_resp_ready_i,
  output logic [31:0]      m1_resp_data_o,
  output logic [1:0]       m1_resp_resp_o,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [1:0]       dmi_req_op_o,
  output logic [31:0]      dmi_req_data_o,
  input  logic             dmi_resp_valid_i,
  output logic             dmi_resp_ready_o,
  input  logic [31:0]      dmi_resp_data_i,
  input  logic [1:0]       dmi_resp_resp_i,
  output logic             grant_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitResp, StReturn} state_e;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic             winner;
  logic             resp_ready_sel;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stale_q, stale_d;
  logic            timeout;

  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d   = (state_q inside {StIssue, StWaitResp}) ? cnt_q + CntW'(1) : '0;
    stale_d = stale_q && !dmi_resp_valid_i;
    // An abandoned transaction the DM already accepted will still answer later.
    if (timeout && (state_q == StIssue) && dmi_req_ready_i) stale_d = 1'b1;
    if (timeout && (state_q == StWaitResp) && !(dmi_resp_valid_i && !stale_q)) stale_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end
`else
  logic stale_q;
  logic timeout;
  logic unused_timeout;

  assign stale_q        = 1'b0;
  assign timeout        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // last_q holds the previous winner; resetting it to 1 makes requester 0 win first.
  assign winner         = (m0_req_valid_i && m1_req_valid_i) ? ~last_q : m1_req_valid_i;
  assign resp_ready_sel = grant_q ? m1_resp_ready_i : m0_resp_ready_i;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    addr_d         = addr_q;
    op_d           = op_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    rresp_d        = rresp_q;
    m0_req_ready_o = 1'b0;
    m1_req_ready_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (m0_req_valid_i || m1_req_valid_i) begin
          m0_req_ready_o = !winner;
          m1_req_ready_o = winner;
          grant_d        = winner;
          addr_d         = winner ? m1_req_addr_i : m0_req_addr_i;
          op_d           = winner ? m1_req_op_i : m0_req_op_i;
          wdata_d        = winner ? m1_req_data_i : m0_req_data_i;
          state_d        = StIssue;
        end
      end
      StIssue: begin
        if (timeout) begin
          rdata_d = '0;
          rresp_d = 2'd2;
          state_d = StReturn;
        end else if (dmi_req_ready_i) begin
          state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        if (dmi_resp_valid_i && !stale_q) begin
          rdata_d = dmi_resp_data_i;
          rresp_d = dmi_resp_resp_i;
          state_d = StReturn;
        end else if (timeout) begin
          rdata_d = '0;
          rresp_d = 2'd2;
          state_d = StReturn;
        end
      end
      StReturn: begin
        if (resp_ready_sel) begin
          last_d  = grant_q;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      op_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  assign busy_o           = (state_q != StIdle);
  assign grant_o          = grant_q;
  assign dmi_req_valid_o  = (state_q == StIssue);
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_op_o     = op_q;
  assign dmi_req_data_o   = wdata_q;
  // A stale response must be drained whatever state the FSM is in.
  assign dmi_resp_ready_o = (state_q == StWaitResp) || stale_q;
  assign m0_resp_valid_o  = (state_q == StReturn) && !grant_q;
  assign m1_resp_valid_o  = (state_q == StReturn) && grant_q;
  assign m0_resp_data_o   = rdata_q;
  assign m0_resp_resp_o   = rresp_q;
  assign m1_resp_data_o   = rdata_q;
  assign m1_resp_resp_o   = rresp_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed self-checking bench for dmi_arbiter with a small behavioural DM responder.
module tb_dmi_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m0_req_valid, m0_req_ready_o, m0_resp_valid_o, m0_resp_ready;
  logic [6:0]  m0_req_addr;
  logic [1:0]  m0_req_op, m0_resp_resp_o;
  logic [31:0] m0_req_data, m0_resp_data_o;
  logic        m1_req_valid, m1_req_ready_o, m1_resp_valid_o, m1_resp_ready;
  logic [6:0]  m1_req_addr;
  logic [1:0]  m1_req_op, m1_resp_resp_o;
  logic [31:0] m1_req_data, m1_resp_data_o;
  logic        dmi_req_valid_o, dmi_req_ready, dmi_resp_valid, dmi_resp_ready_o;
  logic [6:0]  dmi_req_addr_o;
  logic [1:0]  dmi_req_op_o, dmi_resp_resp;
  logic [31:0] dmi_req_data_o, dmi_resp_data;
  logic        grant_o, busy_o;

  dmi_arbiter #(.ABITS(7), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_valid_i(m0_req_valid), .m0_req_ready_o(m0_req_ready_o),
    .m0_req_addr_i(m0_req_addr), .m0_req_op_i(m0_req_op), .m0_req_data_i(m0_req_data),
    .m0_resp_valid_o(m0_resp_valid_o), .m0_resp_ready_i(m0_resp_ready),
    .m0_resp_data_o(m0_resp_data_o), .m0_resp_resp_o(m0_resp_resp_o),
    .m1_req_valid_i(m1_req_valid), .m1_req_ready_o(m1_req_ready_o),
    .m1_req_addr_i(m1_req_addr), .m1_req_op_i(m1_req_op), .m1_req_data_i(m1_req_data),
    .m1_resp_valid_o(m1_resp_valid_o), .m1_resp_ready_i(m1_resp_ready),
    .m1_resp_data_o(m1_resp_data_o), .m1_resp_resp_o(m1_resp_resp_o),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready),
    .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_op_o(dmi_req_op_o),
    .dmi_req_data_o(dmi_req_data_o),
    .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(dmi_resp_ready_o),
    .dmi_resp_data_i(dmi_resp_data), .dmi_resp_resp_i(dmi_resp_resp),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rc0      = 0;
  int rc1      = 0;
  int gq[$];
  always @(posedge clk) cyc <= cyc + 1;

  // Count response-valid cycles per requester and record every request handshake winner.
  always @(negedge clk) begin
    if (m0_resp_valid_o) rc0++;
    if (m1_resp_valid_o) rc1++;
    if (m0_req_ready_o) gq.push_back(0);
    if (m1_req_ready_o) gq.push_back(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_m0"}, {m0_req_ready_o, m0_resp_valid_o, m0_resp_data_o, m0_resp_resp_o}, 0);
    check_eq({tag, "_m1"}, {m1_req_ready_o, m1_resp_valid_o, m1_resp_data_o, m1_resp_resp_o}, 0);
    check_eq({tag, "_dmi"}, {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
                             dmi_resp_ready_o}, 0);
    check_eq({tag, "_status"}, {grant_o, busy_o}, 0);
  endtask

  // Behavioural DM: answers 3 cycles after accepting; dm_mute withholds the answer.
  bit          dm_ready_en = 1'b1;
  bit          dm_mute     = 1'b0;
  bit          dm_pending  = 1'b0;
  bit          dm_acc, dm_cons;
  int          dm_cnt;
  logic [6:0]  dm_addr, acc_addr;
  logic [1:0]  dm_op, acc_op;
  logic [31:0] acc_data;
  logic [6:0]  log_addr[$];
  logic [1:0]  log_op[$];
  logic [31:0] log_data[$];

  function automatic logic [31:0] dm_rdata(input logic [6:0] a);
    return (a == 7'h11) ? 32'h0040_0382 : (32'hCAFE_0000 | {25'd0, a});
  endfunction

  initial begin
    dmi_req_ready  = 1'b0;
    dmi_resp_valid = 1'b0;
    dmi_resp_data  = '0;
    dmi_resp_resp  = '0;
    forever begin
      @(negedge clk);
      dm_acc   = dmi_req_valid_o && dmi_req_ready;
      dm_cons  = dmi_resp_valid && dmi_resp_ready_o;
      acc_addr = dmi_req_addr_o;
      acc_op   = dmi_req_op_o;
      acc_data = dmi_req_data_o;
      @(posedge clk);
      #2;
      if (!rst_n) begin
        dm_pending     = 1'b0;
        dmi_resp_valid = 1'b0;
        dmi_req_ready  = 1'b0;
      end else begin
        if (dm_cons) dmi_resp_valid = 1'b0;
        if (dm_acc) begin
          log_addr.push_back(acc_addr);
          log_op.push_back(acc_op);
          log_data.push_back(acc_data);
          dm_addr    = acc_addr;
          dm_op      = acc_op;
          dm_cnt     = 3;
          dm_pending = 1'b1;
        end else if (dm_pending && !dm_mute) begin
          dm_cnt--;
          if (dm_cnt == 0) begin
            dmi_resp_valid = 1'b1;
            dmi_resp_data  = dm_rdata(dm_addr);
            dmi_resp_resp  = (dm_op == 2'd0) ? 2'd3 : 2'd0;
            dm_pending     = 1'b0;
          end
        end
        dmi_req_ready = dm_ready_en;
      end
    end
  end

  task automatic drive_req(input bit m, input bit v, input logic [6:0] a, input logic [1:0] op,
                           input logic [31:0] d);
    if (m) begin
      m1_req_valid = v; m1_req_addr = a; m1_req_op = op; m1_req_data = d;
    end else begin
      m0_req_valid = v; m0_req_addr = a; m0_req_op = op; m0_req_data = d;
    end
  endtask

  task automatic req_phase(input bit m, input logic [6:0] a, input logic [1:0] op,
                           input logic [31:0] d, output int t_issue);
    bit hs;
    hs = 1'b0;
    drive_req(m, 1'b1, a, op, d);
    for (int i = 0; i < 300 && !hs; i++) begin
      @(negedge clk);
      hs = m ? m1_req_ready_o : m0_req_ready_o;
      @(posedge clk);
      #1;
    end
    drive_req(m, 1'b0, a, op, d);
    t_issue = cyc;
    check_eq("req_handshake", hs, 1);
    check_eq("grant", grant_o, m);
    @(negedge clk);
    check_eq("issue_latency", {dmi_req_valid_o, dmi_req_op_o, dmi_req_addr_o, dmi_req_data_o},
             {1'b1, op, a, d});
  endtask

  task automatic resp_phase(input bit m, output logic [31:0] rd, output logic [1:0] rr,
                            output int t_resp);
    bit got;
    got = 1'b0; rd = '0; rr = '0; t_resp = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (m ? (m1_resp_valid_o && m1_resp_ready) : (m0_resp_valid_o && m0_resp_ready)) begin
        got    = 1'b1;
        rd     = m ? m1_resp_data_o : m0_resp_data_o;
        rr     = m ? m1_resp_resp_o : m0_resp_resp_o;
        t_resp = cyc;
      end
    end
    check_eq("resp_handshake", got, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic master(input bit m, input logic [6:0] a, input logic [1:0] op,
                        input logic [31:0] d, output logic [31:0] rd, output logic [1:0] rr);
    int t0, t1;
    req_phase(m, a, op, d, t0);
    resp_phase(m, rd, rr, t1);
  endtask

  logic [31:0] rd0, rd1, rda[3], rdb[3];
  logic [1:0]  rr0, rr1, rra[3], rrb[3];
  logic [42:0] snap;
  logic [33:0] rsnap;
  int          base, gb, n, c0, c1, t_iss, t_rsp;
  bit          seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    m0_resp_ready = 1'b1;
    m1_resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single m0 read of dmstatus.
    master(0, 7'h11, 2'd1, 32'h0, rd0, rr0);
    check_eq("m0_read_resp", {rd0, rr0}, {32'h0040_0382, 2'd0});
    check_eq("m1_resp_quiet", rc1, 0);
    check_eq("dm_saw_read", {log_addr[log_addr.size()-1], log_op[log_op.size()-1]}, {7'h11, 2'd1});

    // DM stalls the request 5 cycles, m1 stalls the response 4 cycles.
    dm_ready_en   = 1'b0;
    m1_resp_ready = 1'b0;
    fork
      master(1, 7'h04, 2'd2, 32'h1234_5678, rd1, rr1);
      begin
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          seen = dmi_req_valid_o;
        end
        snap = {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o, 1'b0};
        n = 0;
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          if ({dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o, 1'b0} == snap) n++;
        end
        check_eq("issue_hold", n, 5);
        check_eq("issue_payload", snap, {1'b1, 7'h04, 2'd2, 32'h1234_5678, 1'b0});
        @(posedge clk);
        #1;
        dm_ready_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          seen = m1_resp_valid_o;
        end
        rsnap = {m1_resp_data_o, m1_resp_resp_o};
        n = 0;
        for (int k = 0; k < 4; k++) begin
          if (k > 0) @(negedge clk);
          if (m1_resp_valid_o && ({m1_resp_data_o, m1_resp_resp_o} == rsnap)) n++;
        end
        check_eq("resp_hold", n, 4);
        @(posedge clk);
        #1;
        m1_resp_ready = 1'b1;
      end
    join
    check_eq("m1_write_resp", {rd1, rr1}, {32'hCAFE_0004, 2'd0});
    check_eq("dm_saw_write_data", log_data[log_data.size()-1], 32'h1234_5678);

    // Simultaneous requests: m0 write first, then m1 read.
    base = log_addr.size();
    gb   = gq.size();
    fork
      master(0, 7'h10, 2'd2, 32'h1, rd0, rr0);
      master(1, 7'h16, 2'd1, 32'h0, rd1, rr1);
    join
    check_eq("par_grant_order", {gq[gb], gq[gb+1]}, {32'd0, 32'd1});
    check_eq("par_dm_first", {log_addr[base], log_op[base], log_data[base]},
             {7'h10, 2'd2, 32'h1});
    check_eq("par_dm_second", {log_addr[base+1], log_op[base+1]}, {7'h16, 2'd1});
    check_eq("par_m0_resp", {rd0, rr0}, {32'hCAFE_0010, 2'd0});
    check_eq("par_m1_resp", {rd1, rr1}, {32'hCAFE_0016, 2'd0});

    // Both continuously valid for six transactions; m1's last is a nop.
    gb = gq.size();
    fork
      begin
        for (int i = 0; i < 3; i++) master(0, 7'(32 + i), 2'd1, 32'h0, rda[i], rra[i]);
      end
      begin
        for (int i = 0; i < 3; i++)
          master(1, 7'(48 + i), (i == 2) ? 2'd0 : 2'd1, 32'h0, rdb[i], rrb[i]);
      end
    join
    check_eq("rr_count", gq.size() - gb, 6);
    for (int i = 0; i < 6; i++) check_eq("rr_alternate", gq[gb+i], i % 2);
    for (int i = 0; i < 3; i++) begin
      check_eq("rr_m0_resp", {rda[i], rra[i]}, {32'hCAFE_0020 + 32'(i), 2'd0});
      check_eq("rr_m1_resp", {rdb[i], rrb[i]}, {32'hCAFE_0030 + 32'(i), (i == 2) ? 2'd3 : 2'd0});
    end

    // Reset while waiting for the DM response.
    c0 = rc0;
    dm_mute = 1'b1;
    req_phase(0, 7'h05, 2'd1, 32'h0, t_iss);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("in_wait_resp", {busy_o, dmi_resp_ready_o}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    dm_mute = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
    master(1, 7'h11, 2'd1, 32'h0, rd1, rr1);
    check_eq("post_reset_m1", {rd1, rr1}, {32'h0040_0382, 2'd0});
    check_eq("aborted_not_delivered", rc0, c0);

`ifdef DMI_ARB_TIMEOUT_EN
    // DM never answers: watchdog fails the transaction, the late answer is drained.
    dm_mute = 1'b1;
    req_phase(0, 7'h11, 2'd1, 32'h0, t_iss);
    resp_phase(0, rd0, rr0, t_rsp);
    check_eq("timeout_cycles", t_rsp - t_iss, 16);
    check_eq("timeout_resp", {rd0, rr0}, {32'h0, 2'd2});
    c0 = rc0;
    c1 = rc1;
    dm_mute = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("stale_consumed", dmi_resp_valid, 0);
    check_eq("stale_not_delivered", {rc0, rc1}, {c0, c1});
    master(0, 7'h04, 2'd1, 32'h0, rd0, rr0);
    check_eq("after_timeout_resp", {rd0, rr0}, {32'hCAFE_0004, 2'd0});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
